// File: rtl/ram_mem_wait_if.sv
// ram_mem_wait request/response bus.
// Master issues requests, slave (the RAM) answers.
interface ram_mem_wait_if #(
  parameter int WORD_WIDTH = 16,
  parameter int AW         = 16
) ();
  localparam int BYTES = WORD_WIDTH / 8;

  logic                  en_i;
  logic                  we_i;
  logic [BYTES-1:0]      be_i;
  logic [AW-1:0]         addr_i;
  logic [WORD_WIDTH-1:0] data_i;
  logic                  ready_o;
  logic                  valid_o;
  logic [WORD_WIDTH-1:0] data_o_a;
  logic [WORD_WIDTH-1:0] data_o_b;

  modport master (
    output en_i, we_i, be_i, addr_i, data_i,
    input  ready_o, valid_o, data_o_a, data_o_b
  );

  modport slave (
    input  en_i, we_i, be_i, addr_i, data_i,
    output ready_o, valid_o, data_o_a, data_o_b
  );
endinterface

// File: rtl/ram_mem_wait.sv
// Simulation RAM returning word pairs (addr, addr+1)
// with byte-enable writes and programmable wait states.
module ram_mem_wait #(
  parameter int    WORD_WIDTH  = 16,
  parameter int    DEPTH       = 65536,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input logic          clk,
  input logic          reset,
  ram_mem_wait_if.slave bus
);
  localparam int BYTES = WORD_WIDTH / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [WORD_WIDTH-1:0] r_mem [DEPTH];

  state_t                r_state;
  state_t                w_state_n;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_n;
  logic                  r_valid;
  logic                  r_pend_rd;
  logic [WORD_WIDTH-1:0] r_pend_a;
  logic [WORD_WIDTH-1:0] r_pend_b;
  logic [WORD_WIDTH-1:0] r_out_a;
  logic [WORD_WIDTH-1:0] r_out_b;

  logic                  w_ready;
  logic                  w_acc;
  logic                  w_resp;
  logic                  w_resp_rd;
  logic [AW-1:0]         w_addr_nx;
  logic [WORD_WIDTH-1:0] w_rd_a;
  logic [WORD_WIDTH-1:0] w_rd_b;
  logic [WORD_WIDTH-1:0] w_src_a;
  logic [WORD_WIDTH-1:0] w_src_b;

  assign w_ready   = (r_state == S_IDLE);
  assign w_acc     = bus.en_i & w_ready;
  assign w_addr_nx = bus.addr_i + 1'b1;
  assign w_rd_a    = r_mem[bus.addr_i];
  assign w_rd_b    = r_mem[w_addr_nx];

  // zero-wait responses come straight from the array
  assign w_src_a   = (r_state == S_IDLE) ? w_rd_a : r_pend_a;
  assign w_src_b   = (r_state == S_IDLE) ? w_rd_b : r_pend_b;
  assign w_resp_rd = (r_state == S_IDLE) ? ~bus.we_i : r_pend_rd;

  assign bus.ready_o  = w_ready;
  assign bus.valid_o  = r_valid;
  assign bus.data_o_a = r_out_a;
  assign bus.data_o_b = r_out_b;

  // next state, wait counter and response strobe
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_resp    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (WAIT_STATES == 0) begin
            w_resp = 1'b1;
          end else begin
            w_state_n = S_WAIT;
            w_cnt_n   = WS;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_n = S_IDLE;
          w_cnt_n   = 4'd0;
          w_resp    = 1'b1;
        end else begin
          w_cnt_n = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = 4'd0;
      end
    endcase
  end

  // FSM, response registers and array writes;
  // reset blocks a same-cycle write but keeps contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_valid   <= 1'b0;
      r_pend_rd <= 1'b0;
      r_pend_a  <= '0;
      r_pend_b  <= '0;
      r_out_a   <= '0;
      r_out_b   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_valid <= w_resp;
      if (w_acc) begin
        r_pend_rd <= ~bus.we_i;
        r_pend_a  <= w_rd_a;
        r_pend_b  <= w_rd_b;
      end
      if (w_resp && w_resp_rd) begin
        r_out_a <= w_src_a;
        r_out_b <= w_src_b;
      end
      if (w_acc && bus.we_i) begin
        for (int i = 0; i < BYTES; i++) begin
          if (bus.be_i[i]) begin
            r_mem[bus.addr_i][i*8 +: 8] <= bus.data_i[i*8 +: 8];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ram_mem_wait.sv
// Scoreboard bench for ram_mem_wait: three instances
// with 0, 3 and 2 wait states sharing one clock.
module tb_ram_mem_wait;
  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AW = 4;

  typedef struct packed {
    logic        rd;
    logic [15:0] a;
    logic [15:0] b;
    int          cyc;
  } exp_t;

  exp_t sbq [3][$];

  logic        clk = 1'b0;
  logic        rst [3];
  logic        en  [3];
  logic        we  [3];
  logic [1:0]  be  [3];
  logic [3:0]  ad  [3];
  logic [15:0] di  [3];
  logic        rdy [3];
  logic        vld [3];
  logic [15:0] qa  [3];
  logic [15:0] qb  [3];

  logic [15:0] mdl [3][16];

  int cyc    = 0;
  int n_chk  = 0;
  int n_err  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      localparam int WSG = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
      logic [15:0] last_a = '0;
      logic [15:0] last_b = '0;

      ram_mem_wait_if #(.WORD_WIDTH(W), .AW(AW)) bif ();

      assign bif.en_i   = en[g];
      assign bif.we_i   = we[g];
      assign bif.be_i   = be[g];
      assign bif.addr_i = ad[g];
      assign bif.data_i = di[g];
      assign rdy[g]     = bif.ready_o;
      assign vld[g]     = bif.valid_o;
      assign qa[g]      = bif.data_o_a;
      assign qb[g]      = bif.data_o_b;

      ram_mem_wait #(
        .WORD_WIDTH (W),
        .DEPTH      (D),
        .WAIT_STATES(WSG),
        .INIT_FILE  ("")
      ) u_dut (
        .clk  (clk),
        .reset(rst[g]),
        .bus  (bif.slave)
      );

      always @(negedge clk) begin : mon
        exp_t e;
        if (rst[g]) begin
          sbq[g].delete();
          last_a = '0;
          last_b = '0;
        end else if (vld[g]) begin
          if (sbq[g].size() == 0) begin
            chk($sformatf("spurious_valid%0d", g), 32'd1, 32'd0);
          end else begin
            e = sbq[g].pop_front();
            chk($sformatf("latency%0d", g), cyc, e.cyc);
            if (e.rd) begin
              chk($sformatf("rd_a%0d", g), {16'd0, qa[g]}, {16'd0, e.a});
              chk($sformatf("rd_b%0d", g), {16'd0, qb[g]}, {16'd0, e.b});
              last_a = e.a;
              last_b = e.b;
            end else begin
              chk($sformatf("wr_hold_a%0d", g), {16'd0, qa[g]}, {16'd0, last_a});
              chk($sformatf("wr_hold_b%0d", g), {16'd0, qb[g]}, {16'd0, last_b});
            end
          end
        end
      end
    end
  endgenerate

  task automatic do_req(input int d, input logic w, input logic [1:0] b,
                        input logic [3:0] a, input logic [15:0] x);
    exp_t       e;
    int         n;
    logic [3:0] nx;
    @(negedge clk);
    en[d] = 1'b1;
    we[d] = w;
    be[d] = b;
    ad[d] = a;
    di[d] = x;
    n = 0;
    while (!rdy[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[d]) begin
      chk("ready_timeout", 32'd0, 32'd1);
      en[d] = 1'b0;
      return;
    end
    e.cyc = cyc + 1 + ws_of(d);
    e.rd  = ~w;
    e.a   = '0;
    e.b   = '0;
    if (w) begin
      for (int i = 0; i < 2; i++)
        if (b[i]) mdl[d][a][i*8 +: 8] = x[i*8 +: 8];
    end else begin
      nx  = a + 4'd1;
      e.a = mdl[d][a];
      e.b = mdl[d][nx];
    end
    sbq[d].push_back(e);
    @(posedge clk);
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    en[d] = 1'b0;
  endtask

  task automatic chk_rst(input int d, input string t);
    chk({t, "_ready"}, {31'd0, rdy[d]}, 32'd1);
    chk({t, "_valid"}, {31'd0, vld[d]}, 32'd0);
    chk({t, "_qa"}, {16'd0, qa[d]}, 32'd0);
    chk({t, "_qb"}, {16'd0, qb[d]}, 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      en[d]  = 1'b0;
      we[d]  = 1'b0;
      be[d]  = '0;
      ad[d]  = '0;
      di[d]  = '0;
      for (int i = 0; i < 16; i++) mdl[d][i] = 'x;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) chk_rst(d, $sformatf("reset%0d", d));
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;

    // fill every word so no read touches X
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++)
        do_req(d, 1'b1, 2'b11, 4'(i), 16'($urandom));
      idle(d);
    end

    // basic write/read, byte enables, wrap
    do_req(0, 1'b1, 2'b11, 4'd5, 16'hBEEF);
    do_req(0, 1'b0, 2'b00, 4'd5, 16'h0);
    do_req(0, 1'b1, 2'b11, 4'd7, 16'h1234);
    do_req(0, 1'b1, 2'b10, 4'd7, 16'hAB00);
    do_req(0, 1'b0, 2'b00, 4'd7, 16'h0);
    do_req(0, 1'b1, 2'b11, 4'd15, 16'h1111);
    do_req(0, 1'b1, 2'b11, 4'd0, 16'h2222);
    do_req(0, 1'b0, 2'b00, 4'd15, 16'h0);
    do_req(0, 1'b1, 2'b00, 4'd3, 16'hFFFF);
    do_req(0, 1'b0, 2'b11, 4'd3, 16'h0);
    idle(0);
    chk("be_model", {16'd0, mdl[0][7]}, 32'h0000AB34);

    // back-to-back reads then a write response
    do_req(0, 1'b0, 2'b00, 4'd1, 16'h0);
    do_req(0, 1'b0, 2'b00, 4'd2, 16'h0);
    do_req(0, 1'b0, 2'b00, 4'd3, 16'h0);
    do_req(0, 1'b1, 2'b11, 4'd2, 16'hC0DE);
    do_req(0, 1'b0, 2'b00, 4'd2, 16'h0);
    idle(0);

    // three wait states; stray en while busy
    do_req(1, 1'b0, 2'b00, 4'd4, 16'h0);
    @(negedge clk);
    en[1] = 1'b0;
    chk("ws3_rdy_n1", {31'd0, rdy[1]}, 32'd0);
    @(negedge clk);
    en[1] = 1'b1;
    chk("ws3_rdy_n2", {31'd0, rdy[1]}, 32'd0);
    @(negedge clk);
    en[1] = 1'b0;
    chk("ws3_rdy_n3", {31'd0, rdy[1]}, 32'd0);
    chk("ws3_vld_n3", {31'd0, vld[1]}, 32'd0);
    @(negedge clk);
    chk("ws3_rdy_n4", {31'd0, rdy[1]}, 32'd1);
    chk("ws3_vld_n4", {31'd0, vld[1]}, 32'd1);
    do_req(1, 1'b1, 2'b01, 4'd4, 16'h77AA);
    do_req(1, 1'b0, 2'b00, 4'd4, 16'h0);
    idle(1);

    // reset while a write is waiting
    do_req(2, 1'b1, 2'b11, 4'd9, 16'h5A5A);
    @(negedge clk);
    en[2]  = 1'b0;
    rst[2] = 1'b1;
    #1;
    chk_rst(2, "midrst");
    repeat (2) @(negedge clk);
    rst[2] = 1'b0;
    repeat (4) @(negedge clk);
    chk_rst(2, "postrst");
    do_req(2, 1'b0, 2'b00, 4'd9, 16'h0);
    idle(2);
    chk("rst_keep_model", {16'd0, mdl[2][9]}, 32'h00005A5A);

    repeat (10) @(negedge clk);
    for (int d = 0; d < 3; d++)
      chk($sformatf("sb_empty%0d", d), sbq[d].size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
